// File: rtl/axis_acq_pkg.sv
// Shared types and constants for the acquisition run scheduler.
package axis_acq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } acq_state_e;

  // The selection stage's largest coincidence sum is 6, so 7 lets nothing through.
  localparam logic [2:0] SEL_DISABLE = 3'd7;
  localparam int         ARM_CYCLES  = 2;

endpackage

// File: rtl/axis_acq_if.sv
// AXI-Stream style event bus. slave_nr is for producers that cannot be stalled.
interface axis_acq_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master   (output tdata, tvalid, input tready);
  modport slave    (input tdata, tvalid, output tready);
  modport slave_nr (input tdata, tvalid);
endinterface

// File: rtl/axis_acq_out_reg.sv
// One-entry output register between a non-stallable source and a
// back-pressured consumer; flags each eligible beat as loaded or dropped.
module axis_acq_out_reg #(
  parameter int DATA_WIDTH = 128
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load_en_i,
  axis_acq_if.slave_nr      s_axis,
  axis_acq_if.master        m_axis,
  output logic              load_o,
  output logic              drop_o,
  output logic              tvalid_next_o
);

  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  eligible;

  assign eligible      = load_en_i & s_axis.tvalid;
  assign load_o        = eligible & (~tvalid_q | m_axis.tready);
  assign drop_o        = eligible & ~load_o;
  assign tvalid_next_o = load_o | (tvalid_q & ~m_axis.tready);

  // NOTE: the data register is reset too, so a beat held at reset can never resurface.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= tvalid_next_o;
      if (load_o) tdata_q <= s_axis.tdata;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;

endmodule

// File: rtl/axis_acq_scheduler.sv
// Run controller: arms the selection stage, gates the event stream for a run
// bounded by event count, cycle count or stop, and keeps run statistics.
module axis_acq_scheduler
  import axis_acq_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNTR_WIDTH-1:0] max_events,
  input  logic [CNTR_WIDTH-1:0] max_cycles,
  input  logic [2:0]            threshold,
  output logic [2:0]            sel_cfg,
  axis_acq_if.slave_nr          s_axis,
  axis_acq_if.master            m_axis,
  output logic [CNTR_WIDTH-1:0] event_cntr,
  output logic [CNTR_WIDTH-1:0] drop_cntr,
  output logic [CNTR_WIDTH-1:0] cycle_cntr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNTR_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [1:0]            ARM_LAST = 2'(ARM_CYCLES - 1);

  function automatic logic [CNTR_WIDTH-1:0] sat_inc(input logic [CNTR_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNTR_WIDTH'(1);
  endfunction

  acq_state_e            state_q;
  logic                  start_q;
  logic [1:0]            arm_cnt_q;
  logic [2:0]            sel_cfg_q;
  logic [CNTR_WIDTH-1:0] max_events_q, max_cycles_q;
  logic [CNTR_WIDTH-1:0] event_cntr_q, drop_cntr_q, cycle_cntr_q;
  logic                  busy_q, done_q;

  logic                  load_en, load, drop, tvalid_next;
  logic [CNTR_WIDTH-1:0] evt_inc, cyc_inc;
  logic                  evt_hit, cyc_hit;

  // A beat that coincides with stop is neither loaded nor counted as dropped.
  assign load_en = (state_q == ST_RUN) & ~stop;

  axis_acq_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .load_en_i     (load_en),
    .s_axis        (s_axis),
    .m_axis        (m_axis),
    .load_o        (load),
    .drop_o        (drop),
    .tvalid_next_o (tvalid_next)
  );

  assign evt_inc = sat_inc(event_cntr_q);
  assign cyc_inc = sat_inc(cycle_cntr_q);
  assign evt_hit = load && (max_events_q != '0) && (evt_inc == max_events_q);
  assign cyc_hit = (max_cycles_q != '0) && (cyc_inc == max_cycles_q);

  // NOTE: every update below is non-blocking, so all branches see this cycle's _q values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      arm_cnt_q    <= '0;
      sel_cfg_q    <= SEL_DISABLE;
      max_events_q <= '0;
      max_cycles_q <= '0;
      event_cntr_q <= '0;
      drop_cntr_q  <= '0;
      cycle_cntr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_q <= start;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !start_q) begin
            state_q      <= ST_ARM;
            arm_cnt_q    <= '0;
            max_events_q <= max_events;
            max_cycles_q <= max_cycles;
            sel_cfg_q    <= threshold;
            event_cntr_q <= '0;
            drop_cntr_q  <= '0;
            cycle_cntr_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        ST_ARM: begin
          if (arm_cnt_q == ARM_LAST) state_q   <= ST_RUN;
          else                       arm_cnt_q <= arm_cnt_q + 2'd1;
        end
        ST_RUN: begin
          cycle_cntr_q <= cyc_inc;
          if (load) event_cntr_q <= evt_inc;
          if (drop) drop_cntr_q  <= sat_inc(drop_cntr_q);
          if (stop || evt_hit || cyc_hit) begin
            state_q   <= ST_DONE;
            sel_cfg_q <= SEL_DISABLE;
            busy_q    <= 1'b0;
            done_q    <= ~tvalid_next;
          end
        end
        ST_DONE: begin
          if (!start) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end else begin
            done_q  <= ~tvalid_next;
          end
        end
      endcase
    end
  end

  assign sel_cfg    = sel_cfg_q;
  assign event_cntr = event_cntr_q;
  assign drop_cntr  = drop_cntr_q;
  assign cycle_cntr = cycle_cntr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_axis_acq_scheduler.sv
// Directed bench for axis_acq_scheduler: scalar checks plus a scoreboard of
// expected output beats consumed by an independent monitor.
module tb_axis_acq_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start, stop;
  logic [31:0] max_events, max_cycles;
  logic [2:0]  threshold;
  logic [2:0]  sel_cfg;
  logic [31:0] event_cntr, drop_cntr, cycle_cntr;
  logic        busy, done;

  axis_acq_if #(.DATA_WIDTH(128)) s_if ();
  axis_acq_if #(.DATA_WIDTH(128)) m_if ();

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] sb[$];

  always #5 aclk = ~aclk;

  axis_acq_scheduler #(.DATA_WIDTH(128), .CNTR_WIDTH(32)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .stop       (stop),
    .max_events (max_events),
    .max_cycles (max_cycles),
    .threshold  (threshold),
    .sel_cfg    (sel_cfg),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .event_cntr (event_cntr),
    .drop_cntr  (drop_cntr),
    .cycle_cntr (cycle_cntr),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [127:0] mk(input int i);
    return {4{32'hA500_0000 + 32'(i)}};
  endfunction

  // Transfers complete at the next posedge when valid and ready are both high.
  initial begin
    forever begin
      @(negedge aclk);
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got %0h expected no beat", m_if.tdata);
        end else begin
          check("sb_data", m_if.tdata, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Start edge at cycle t; returns positioned so the next driven beat is in the first RUN cycle.
  task automatic run_start(input logic [31:0] me, input logic [31:0] mc, input logic [2:0] th);
    max_events = me;
    max_cycles = mc;
    threshold  = th;
    start      = 1'b1;
    tick();
    check("arm_sel_cfg", sel_cfg, th);
    check("arm_busy", busy, 1);
    check("arm_evt_clr", event_cntr, 0);
    check("arm_cyc_clr", cycle_cntr, 0);
    threshold = ~th;
    tick();
    tick();
    check("run_sel_latched", sel_cfg, th);
  endtask

  initial begin
    aresetn     = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    max_events  = '0;
    max_cycles  = '0;
    threshold   = '0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tready = 1'b0;
    m_if.tready = 1'b0;
    tick();
    tick();
    check("rst_sel_cfg", sel_cfg, 3'd7);
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tdata", m_if.tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_evt", event_cntr, 0);
    aresetn = 1'b1;
    tick();

    // Event-limited run with a free-flowing consumer.
    m_if.tready = 1'b1;
    run_start(32'd4, 32'd0, 3'd2);
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = mk(i);
      if (i < 4) sb.push_back(mk(i));
      tick();
      if (i == 0) check("t1_latency", m_if.tvalid, 1);
      if (i == 3) begin
        check("t1_evt_at_done", event_cntr, 4);
        check("t1_busy_off", busy, 0);
        check("t1_sel_off", sel_cfg, 3'd7);
        check("t1_done_wait", done, 0);
      end
    end
    s_if.tvalid = 1'b0;
    check("t1_evt_hold", event_cntr, 4);
    check("t1_drop", drop_cntr, 0);
    check("t1_cyc", cycle_cntr, 4);
    check("t1_done", done, 1);
    start = 1'b0;
    tick();
    check("t1_idle_done", done, 0);

    // Cycle-limited run.
    run_start(32'd0, 32'd10, 3'd5);
    for (int i = 0; i < 12; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = mk(100 + i);
      if (i < 10) sb.push_back(mk(100 + i));
      tick();
      if (i == 8) check("t2_busy_c9", busy, 1);
      if (i == 9) begin
        check("t2_busy_c10", busy, 0);
        check("t2_cyc", cycle_cntr, 10);
        check("t2_sel_off", sel_cfg, 3'd7);
      end
    end
    s_if.tvalid = 1'b0;
    check("t2_evt", event_cntr, 10);
    check("t2_cyc_hold", cycle_cntr, 10);
    check("t2_drop", drop_cntr, 0);
    start = 1'b0;
    tick();

    // Back-pressure: first beat held, the rest dropped; done waits for drain.
    m_if.tready = 1'b0;
    run_start(32'd0, 32'd0, 3'd3);
    for (int i = 0; i < 3; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = mk(200 + i);
      if (i == 0) sb.push_back(mk(200));
      tick();
    end
    s_if.tvalid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_busy", busy, 0);
    check("t3_done_held", done, 0);
    check("t3_tvalid", m_if.tvalid, 1);
    check("t3_drop", drop_cntr, 2);
    check("t3_evt", event_cntr, 1);
    check("t3_cyc", cycle_cntr, 4);
    tick();
    check("t3_done_still", done, 0);
    m_if.tready = 1'b1;
    tick();
    check("t3_done_drained", done, 1);
    check("t3_tvalid_clr", m_if.tvalid, 0);
    start = 1'b0;
    tick();

    // Stop coincides with the beat that would reach the event limit.
    run_start(32'd3, 32'd0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = mk(250 + i);
      stop        = (i == 2);
      if (i < 2) sb.push_back(mk(250 + i));
      tick();
    end
    s_if.tvalid = 1'b0;
    stop = 1'b0;
    check("t4_evt", event_cntr, 2);
    check("t4_drop", drop_cntr, 0);
    check("t4_busy", busy, 0);
    check("t4_sel_off", sel_cfg, 3'd7);
    check("t4_done", done, 1);
    start = 1'b0;
    tick();

    // Reset in RUN with a beat pending in the output register.
    m_if.tready = 1'b0;
    run_start(32'd0, 32'd0, 3'd4);
    s_if.tvalid = 1'b1;
    s_if.tdata  = mk(300);
    sb.push_back(mk(300));
    tick();
    s_if.tvalid = 1'b0;
    tick();
    check("t5_pending", m_if.tvalid, 1);
    aresetn = 1'b0;
    start   = 1'b0;
    sb.delete();
    tick();
    check("t5_sel_cfg", sel_cfg, 3'd7);
    check("t5_tvalid", m_if.tvalid, 0);
    check("t5_tdata", m_if.tdata, 0);
    check("t5_evt", event_cntr, 0);
    check("t5_cyc", cycle_cntr, 0);
    check("t5_busy", busy, 0);
    aresetn = 1'b1;
    m_if.tready = 1'b1;
    tick();
    run_start(32'd2, 32'd0, 3'd6);
    for (int i = 0; i < 2; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = mk(400 + i);
      sb.push_back(mk(400 + i));
      tick();
    end
    s_if.tvalid = 1'b0;
    check("t5_rerun_evt", event_cntr, 2);
    check("t5_rerun_busy", busy, 0);
    tick();
    check("t5_rerun_done", done, 1);

    // Start still high through DONE must not retrigger.
    tick();
    tick();
    tick();
    check("t6_no_retrig_busy", busy, 0);
    check("t6_no_retrig_done", done, 1);
    check("t6_no_retrig_evt", event_cntr, 2);
    start = 1'b0;
    tick();
    check("t6_idle_done", done, 0);
    run_start(32'd1, 32'd0, 3'd0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = mk(500);
    sb.push_back(mk(500));
    tick();
    s_if.tvalid = 1'b0;
    check("t6_evt", event_cntr, 1);
    check("t6_busy", busy, 0);
    tick();
    check("t6_done", done, 1);
    start = 1'b0;
    tick();
    tick();

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
